crp16_alu_logic_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined bitwise-logic unit for the CRP16 ALU, with a valid/ready handshake on both sides.

---
 rtl/crp16_alu_logic_pipe_pkg.sv | 18 +
 rtl/crp16_alu_logic_core.sv | 27 ++
 rtl/crp16_alu_logic_pipe.sv | 92 +++++++++
 tb/tb_crp16_alu_logic_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crp16_alu_logic_pipe_pkg.sv
// Shared definitions for the CRP16 ALU logic unit: operation width and the 8-op encoding.
package crp16_alu_logic_pipe_pkg;

  localparam int LOP_W = 3;

  // op[1:0] keeps the legacy AND/OR/NOT/XOR meaning when op[2]=0.
  typedef enum logic [LOP_W-1:0] {
    LOP_AND  = 3'b000,
    LOP_OR   = 3'b001,
    LOP_NOT  = 3'b010,
    LOP_XOR  = 3'b011,
    LOP_NAND = 3'b100,
    LOP_NOR  = 3'b101,
    LOP_XNOR = 3'b110,
    LOP_ANDN = 3'b111
  } lop_e;

endpackage

// File: rtl/crp16_alu_logic_core.sv
// Combinational bitwise-logic core of the CRP16 ALU: (x, y, op) -> result.
module crp16_alu_logic_core
  import crp16_alu_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [LOP_W-1:0] op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    unique case (lop_e'(op))
      LOP_AND:  result = x & y;
      LOP_OR:   result = x | y;
      LOP_NOT:  result = ~y;
      LOP_XOR:  result = x ^ y;
      LOP_NAND: result = ~(x & y);
      LOP_NOR:  result = ~(x | y);
      LOP_XNOR: result = ~(x ^ y);
      LOP_ANDN: result = x & ~y;
    endcase
  end

endmodule

// File: rtl/crp16_alu_logic_pipe.sv
// Two-stage valid/ready pipelined logic unit for the CRP16 ALU with Z/N flags on consume.
module crp16_alu_logic_pipe
  import crp16_alu_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [LOP_W-1:0] op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n
);

  logic             vld_p1;
  logic             vld_p2;
  logic [WIDTH-1:0] x_p1;
  logic [WIDTH-1:0] y_p1;
  logic [LOP_W-1:0] op_p1;
  logic [WIDTH-1:0] res_p1;
  logic [WIDTH-1:0] res_p2;
  logic             s2_adv;
  logic             accept;
  logic             consume;

  // Ready chain is intentionally combinational from out_ready.
  assign s2_adv   = vld_p1 & (~vld_p2 | out_ready);
  assign in_ready = ~vld_p1 | s2_adv;
  assign accept   = in_valid & in_ready;
  assign consume  = vld_p2 & out_ready;

  // Stage 1: operand capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
      op_p1  <= '0;
    end else begin
      if (accept) begin
        x_p1  <= x;
        y_p1  <= y;
        op_p1 <= op;
      end
      if (accept) begin
        vld_p1 <= 1'b1;
      end else if (s2_adv) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  crp16_alu_logic_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x      (x_p1),
    .y      (y_p1),
    .op     (op_p1),
    .result (res_p1)
  );

  // Stage 2: result register and flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (s2_adv) begin
        res_p2 <= res_p1;
        vld_p2 <= 1'b1;
      end else if (consume) begin
        vld_p2 <= 1'b0;
      end
      if (consume) begin
        flag_z <= (res_p2 == '0);
        flag_n <= res_p2[WIDTH-1];
      end
    end
  end

  assign out_valid = vld_p2;
  assign out       = res_p2;

endmodule

// File: tb/tb_crp16_alu_logic_pipe.sv
// Scoreboard bench for crp16_alu_logic_pipe at WIDTH=16, plus WIDTH=8/32 random sweeps.
module tb_crp16_alu_logic_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  logic        flag_z;
  logic        flag_n;

  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, fz8, fn8;
  logic [7:0]  x8 = '0, y8 = '0, o8;
  logic [2:0]  op8 = '0;
  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, fz32, fn32;
  logic [31:0] x32 = '0, y32 = '0, o32;
  logic [2:0]  op32 = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] sb[$];
  logic [31:0] q8[$];
  logic [31:0] q32[$];
  int          cons_cyc[$];
  logic        mz = 1'b0, mn = 1'b0, mz8 = 1'b0, mn8 = 1'b0, mz32 = 1'b0, mn32 = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_out = '0;
  logic        sweep_on = 1'b0;

  crp16_alu_logic_pipe #(.WIDTH(16)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag_z(flag_z), .flag_n(flag_n)
  );

  crp16_alu_logic_pipe #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .op(op8), .out_valid(ov8), .out_ready(or8),
    .out(o8), .flag_z(fz8), .flag_n(fn8)
  );

  crp16_alu_logic_pipe #(.WIDTH(32)) dut32 (
    .clock(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .x(x32), .y(y32), .op(op32), .out_valid(ov32), .out_ready(or32),
    .out(o32), .flag_z(fz32), .flag_n(fn32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lop_ref(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [31:0] r;
    logic [31:0] m;
    case (o)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~b;
      3'd3:    r = a ^ b;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a ^ b);
      default: r = a & ~b;
    endcase
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return r & m;
  endfunction

  // Main scoreboard: push on predicted accept, pop on predicted consume.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      sb.delete();
      mz = 1'b0;
      mn = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check_eq("stall_hold", 32'(out), 32'(prev_out));
      if (out_valid && out_ready) begin
        check_eq("flag_z", 32'(flag_z), 32'(mz));
        check_eq("flag_n", 32'(flag_n), 32'(mn));
        if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check_eq("out", 32'(out), e);
          mz = (e[15:0] == 16'h0);
          mn = e[15];
          cons_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) sb.push_back(lop_ref(op, 32'(x), 32'(y), 16));
      prev_stall = out_valid && !out_ready;
      prev_out = out;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && sweep_on) begin
      if (ov8 && or8) begin
        check_eq("flag_z_w8", 32'(fz8), 32'(mz8));
        check_eq("flag_n_w8", 32'(fn8), 32'(mn8));
        if (q8.size() == 0) check_eq("sb_underflow_w8", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          check_eq("out_w8", 32'(o8), e);
          mz8 = (e[7:0] == 8'h0);
          mn8 = e[7];
        end
      end
      if (iv8 && ir8) q8.push_back(lop_ref(op8, 32'(x8), 32'(y8), 8));
      if (ov32 && or32) begin
        check_eq("flag_z_w32", 32'(fz32), 32'(mz32));
        check_eq("flag_n_w32", 32'(fn32), 32'(mn32));
        if (q32.size() == 0) check_eq("sb_underflow_w32", 32'd1, 32'd0);
        else begin
          e = q32.pop_front();
          check_eq("out_w32", o32, e);
          mz32 = (e == 32'h0);
          mn32 = e[31];
        end
      end
      if (iv32 && ir32) q32.push_back(lop_ref(op32, x32, y32, 32));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                      output int waits);
    waits = 0;
    in_valid = 1'b1;
    x = a;
    y = b;
    op = o;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits >= 40) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
      n++;
      if (n >= 60) break;
    end
    check_eq("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] tbl[8];
    logic [15:0] held;
    int w;
    int wsum;
    tbl = '{16'hF000, 16'hFFF0, 16'h00FF, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'h00F0};

    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Every op on the reference operands, each result 2 edges after its accept.
    for (int o = 0; o < 8; o++) begin
      send(16'hF0F0, 16'hFF00, 3'(o), w);
      @(negedge clk);
      check_eq("op_early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq("op_valid", 32'(out_valid), 32'd1);
      check_eq("op_result", 32'(out), 32'(tbl[o]));
      @(posedge clk);
      #1;
    end
    drain();

    cons_cyc.delete();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom), 16'($urandom), 3'($urandom), w);
      wsum += w;
    end
    drain();
    check_eq("stream_in_ready", wsum, 32'd0);
    check_eq("stream_count", cons_cyc.size(), 32'd8);
    if (cons_cyc.size() == 8) check_eq("stream_consecutive", cons_cyc[7] - cons_cyc[0], 32'd7);

    out_ready = 1'b0;
    send(16'h1357, 16'h2468, 3'd3, w);
    send(16'hAAAA, 16'h0F0F, 3'd7, w);
    @(negedge clk);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    held = out;
    @(posedge clk);
    #1;
    fork
      send(16'h8001, 16'h7FFE, 3'd1, w);
      begin
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_hold", 32'(out), 32'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check_eq("bp_stalled", 32'(w > 0), 32'd1);
    send(16'h00FF, 16'h0F0F, 3'd4, w);
    send(16'hFFFF, 16'h0000, 3'd5, w);
    send(16'h5555, 16'h3333, 3'd6, w);
    drain();

    send(16'h1234, 16'h1234, 3'd3, w);
    drain();
    check_eq("flag_z_xor", 32'(flag_z), 32'd1);
    check_eq("flag_n_xor", 32'(flag_n), 32'd0);
    out_ready = 1'b0;
    send(16'h0000, 16'h0000, 3'd2, w);
    repeat (3) @(negedge clk);
    check_eq("flag_z_unconsumed", 32'(flag_z), 32'd1);
    check_eq("flag_n_unconsumed", 32'(flag_n), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check_eq("flag_z_not", 32'(flag_z), 32'd0);
    check_eq("flag_n_not", 32'(flag_n), 32'd1);

    // Fill both stages, then reset mid-cycle.
    out_ready = 1'b0;
    send(16'hFFFF, 16'hFFFF, 3'd0, w);
    send(16'h0001, 16'h0002, 3'd1, w);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out", 32'(out), 32'd0);
    check_eq("midrst_flag_z", 32'(flag_z), 32'd0);
    check_eq("midrst_flag_n", 32'(flag_n), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(16'hC3C3, 16'h0FF0, 3'd7, w);
    @(negedge clk);
    @(negedge clk);
    check_eq("post_rst_valid", 32'(out_valid), 32'd1);
    check_eq("post_rst_out", 32'(out), 32'hC003);
    @(posedge clk);
    #1;
    drain();

    sweep_on = 1'b1;
    repeat (400) begin
      iv8 = 1'($urandom_range(0, 1));
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      op8 = 3'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      iv32 = 1'($urandom_range(0, 1));
      x32 = $urandom;
      y32 = $urandom;
      op32 = 3'($urandom);
      or32 = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    iv32 = 1'b0;
    or8 = 1'b1;
    or32 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("sweep_drain_w8", q8.size(), 32'd0);
    check_eq("sweep_drain_w32", q32.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
